stream_bw_test: RTL and testbench

Parametrised stream bandwidth and correctness test engine for the PicoBus stream ports. It sits between one host input stream and one host output stream. It runs in one of three software-selected modes:
- echo-sum: echo each input beat with a running sum and a signature.
- generate: emit a known pattern to the host.
- check: sink the host's pattern and count errors.

It also provides cycle and beat counters, so software can compute sustained bandwidth in each direction.

---
 rtl/stream_bw_test.sv | 219 +++++++++++++++++++++
 tb/tb_stream_bw_test.sv | 384 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_bw_test.sv
// stream_bw_test: stream bandwidth / correctness engine for one input and one
// output stream. Three modes: echo-sum (input beats echoed with running sum,
// index and signature), generate (known lane pattern sent out), and check
// (host pattern sunk and lane mismatches counted). Cycle and beat counters let
// software derive sustained bandwidth in each direction.
module stream_bw_test #(
    parameter int          DATA_W     = 128,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [31:0] SIG        = 32'h42424242
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s1i_valid,
    output logic              s1i_rdy,
    input  logic [DATA_W-1:0] s1i_data,
    output logic              s1o_valid,
    input  logic              s1o_rdy,
    output logic [DATA_W-1:0] s1o_data,
    input  logic [1:0]        mode,
    input  logic              start,
    input  logic [31:0]       beat_target,
    output logic              busy,
    output logic              done,
    output logic [31:0]       cycle_count,
    output logic [31:0]       beats_in,
    output logic [31:0]       beats_out,
    output logic [15:0]       err_count
);

    localparam int LANES = DATA_W / 32;
    localparam int AW    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      state_reg, state_next;
    logic        done_reg, done_next;
    logic [1:0]  mode_reg;
    logic [31:0] target_reg;
    logic [31:0] sum_reg;
    logic [31:0] seq_reg;
    logic [31:0] cycle_reg;
    logic [31:0] bin_reg;
    logic [31:0] bout_reg;
    logic [15:0] err_reg;

    // Output buffer: small array, pointer pair plus occupancy count.
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]       count_reg;

    logic fifo_full, fifo_empty;
    logic is_echo, is_gen, is_chk;
    logic in_hs, pop, push, gen_push;
    logic last_in, last_gen, drain_empty;

    logic [31:0]       sum_new;
    logic [DATA_W-1:0] echo_word, gen_word, push_word;
    logic [LANES-1:0]  lane_err;
    logic [15:0]       err_add;
    logic [16:0]       err_sum;
    logic [15:0]       err_sat;

    assign fifo_full  = (count_reg == DEPTH_C);
    assign fifo_empty = (count_reg == '0);

    assign is_echo = (mode_reg == 2'b00);
    assign is_gen  = (mode_reg == 2'b01);
    assign is_chk  = mode_reg[1];

    // Handshake qualifiers depend only on registered state and full/empty.
    assign s1i_rdy   = (state_reg == RUN) && ((is_echo && !fifo_full) || is_chk);
    assign s1o_valid = !fifo_empty;
    assign s1o_data  = mem[rd_ptr_reg];

    assign in_hs    = s1i_valid && s1i_rdy;
    assign pop      = s1o_valid && s1o_rdy;
    assign gen_push = (state_reg == RUN) && is_gen && !fifo_full;
    assign push     = (in_hs && is_echo) || gen_push;

    assign sum_new  = sum_reg + s1i_data[31:0];
    assign last_in  = (bin_reg == target_reg - 32'd1);
    assign last_gen = (seq_reg == target_reg - 32'd1);
    // Buffer is empty now, or its last beat leaves on this edge.
    assign drain_empty = fifo_empty || ((count_reg == (AW+1)'(1)) && pop);

    // Per-lane pattern generation and comparison: lane j of beat k is k + j.
    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign gen_word[gi*32 +: 32] = seq_reg + 32'(gi);
            assign lane_err[gi] = (s1i_data[gi*32 +: 32] != bin_reg + 32'(gi));
        end
    endgenerate

    // Echo beat: upper input lanes pass through, low 128 bits carry results.
    always_comb begin
        echo_word        = s1i_data;
        echo_word[127:0] = {SIG, bin_reg, sum_new, s1i_data[31:0]};
    end

    assign push_word = is_echo ? echo_word : gen_word;

    // Count mismatching lanes in the current beat and add with saturation.
    always_comb begin
        err_add = 16'd0;
        for (int i = 0; i < LANES; i++) begin
            err_add = err_add + {15'd0, lane_err[i]};
        end
        err_sum = {1'b0, err_reg} + {1'b0, err_add};
        err_sat = err_sum[16] ? 16'hFFFF : err_sum[15:0];
    end

    // Next-state and done-pulse decode.
    always_comb begin
        state_next = state_reg;
        done_next  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (beat_target != 32'd0) begin
                        state_next = RUN;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (is_chk) begin
                    if (in_hs && last_in) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end
                end else if (is_gen) begin
                    if (gen_push && last_gen) begin
                        state_next = DRAIN;
                    end
                end else begin
                    if (in_hs && last_in) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (drain_empty) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State, run configuration, counters and accumulators.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            done_reg   <= 1'b0;
            mode_reg   <= 2'b00;
            target_reg <= 32'd0;
            sum_reg    <= 32'd0;
            seq_reg    <= 32'd0;
            cycle_reg  <= 32'd0;
            bin_reg    <= 32'd0;
            bout_reg   <= 32'd0;
            err_reg    <= 16'd0;
        end else begin
            state_reg <= state_next;
            done_reg  <= done_next;
            if (state_reg == IDLE && start) begin
                mode_reg   <= mode;
                target_reg <= beat_target;
                sum_reg    <= 32'd0;
                seq_reg    <= 32'd0;
                cycle_reg  <= 32'd0;
                bin_reg    <= 32'd0;
                bout_reg   <= 32'd0;
                err_reg    <= 16'd0;
            end else begin
                if (state_reg != IDLE) cycle_reg <= cycle_reg + 32'd1;
                if (in_hs)             bin_reg   <= bin_reg + 32'd1;
                if (pop)               bout_reg  <= bout_reg + 32'd1;
                if (in_hs && is_echo)  sum_reg   <= sum_new;
                if (gen_push)          seq_reg   <= seq_reg + 32'd1;
                if (in_hs && is_chk)   err_reg   <= err_sat;
            end
        end
    end

    // Buffer pointers and occupancy; reset flushes contents logically.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // Buffer storage write port.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_reg] <= push_word;
    end

    assign busy        = (state_reg != IDLE);
    assign done        = done_reg;
    assign cycle_count = cycle_reg;
    assign beats_in    = bin_reg;
    assign beats_out   = bout_reg;
    assign err_count   = err_reg;

endmodule

// File: tb/tb_stream_bw_test.sv
// Testbench for stream_bw_test: scenario tasks drive stimulus, a scoreboard
// queue holds expected output beats and is compared at each output handshake.
module tb_stream_bw_test;

    localparam int          DW    = 256;
    localparam int          DEPTH = 4;
    localparam int          LN    = DW / 32;
    localparam logic [31:0] SIGV  = 32'h42424242;

    logic          clk;
    logic          rst_n;
    logic          s1i_valid;
    logic          s1i_rdy;
    logic [DW-1:0] s1i_data;
    logic          s1o_valid;
    logic          s1o_rdy;
    logic [DW-1:0] s1o_data;
    logic [1:0]    mode;
    logic          start;
    logic [31:0]   beat_target;
    logic          busy;
    logic          done;
    logic [31:0]   cycle_count;
    logic [31:0]   beats_in;
    logic [31:0]   beats_out;
    logic [15:0]   err_count;

    stream_bw_test #(.DATA_W(DW), .FIFO_DEPTH(DEPTH), .SIG(SIGV)) dut (
        .clk(clk), .rst_n(rst_n),
        .s1i_valid(s1i_valid), .s1i_rdy(s1i_rdy), .s1i_data(s1i_data),
        .s1o_valid(s1o_valid), .s1o_rdy(s1o_rdy), .s1o_data(s1o_data),
        .mode(mode), .start(start), .beat_target(beat_target),
        .busy(busy), .done(done), .cycle_count(cycle_count),
        .beats_in(beats_in), .beats_out(beats_out), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] exp_q [$];
    int            checks;
    int            failures;
    int            done_seen;
    int            out_cnt;
    int            valid_seen;
    logic          in_acc;
    logic [31:0]   m_sum;
    logic [31:0]   m_k;

    function automatic logic [DW-1:0] echo_exp(input logic [DW-1:0] d,
                                               input logic [31:0] k,
                                               input logic [31:0] s);
        logic [DW-1:0] r;
        r = d;
        r[127:0] = {SIGV, k, s, d[31:0]};
        return r;
    endfunction

    function automatic logic [DW-1:0] gen_pat(input logic [31:0] k);
        logic [DW-1:0] r;
        for (int j = 0; j < LN; j++) r[j*32 +: 32] = k + 32'(j);
        return r;
    endfunction

    function automatic logic [DW-1:0] make_in(input logic [31:0] low);
        logic [DW-1:0] r;
        for (int j = 1; j < LN; j++) r[j*32 +: 32] = $urandom;
        r[31:0] = low;
        return r;
    endfunction

    // One clock: sample handshakes on the falling edge, then advance.
    task automatic tick();
        logic [DW-1:0] e;
        @(negedge clk);
        in_acc = s1i_valid && s1i_rdy;
        if (done) done_seen++;
        if (s1o_valid) valid_seen++;
        if (s1o_valid && s1o_rdy) begin
            checks++;
            out_cnt++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected got=%h", s1o_data);
            end else begin
                e = exp_q.pop_front();
                if (s1o_data !== e) begin
                    failures++;
                    $display("FAIL sb_data got=%h exp=%h", s1o_data, e);
                end else begin
                    $display("beat out ok data[127:0]=%h", s1o_data[127:0]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [1:0] m, input logic [31:0] n);
        mode        = m;
        beat_target = n;
        start       = 1'b1;
        done_seen   = 0;
        out_cnt     = 0;
        valid_seen  = 0;
        m_sum       = 32'd0;
        m_k         = 32'd0;
        tick();
        start       = 1'b0;
        mode        = 2'b11;
        beat_target = 32'hDEAD;
    endtask

    task automatic feed_echo(input logic [31:0] lows [$], input int budget,
                             output int acc);
        logic [DW-1:0] cur;
        int g;
        acc = 0;
        g   = 0;
        cur = make_in(lows[0]);
        while (acc < lows.size() && g < budget) begin
            s1i_valid = 1'b1;
            s1i_data  = cur;
            tick();
            g++;
            if (in_acc) begin
                m_sum = m_sum + cur[31:0];
                exp_q.push_back(echo_exp(cur, m_k, m_sum));
                $display("beat in  k=%0d low=%h sum=%h", m_k, cur[31:0], m_sum);
                m_k = m_k + 32'd1;
                acc++;
                if (acc < lows.size()) cur = make_in(lows[acc]);
            end
        end
        s1i_valid = 1'b0;
    endtask

    // corrupt: 0 clean, 1 beat 1 lane 3 flipped, 2 every lane inverted
    task automatic feed_check(input int n, input int corrupt, input int budget,
                              output int acc);
        logic [DW-1:0] cur;
        int g;
        acc = 0;
        g   = 0;
        while (acc < n && g < budget) begin
            cur = gen_pat(32'(acc));
            if (corrupt == 1 && acc == 1) cur[3*32] = ~cur[3*32];
            if (corrupt == 2) cur = ~cur;
            s1i_valid = 1'b1;
            s1i_data  = cur;
            tick();
            g++;
            if (in_acc) acc++;
        end
        s1i_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int g;
        g = 0;
        while (done_seen == 0 && g < budget) begin
            tick();
            g++;
        end
        tick();
        checks++;
        if (done_seen !== 1) begin
            failures++;
            $display("FAIL done_pulse got=%0d exp=1", done_seen);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        checks++;
        if ({busy, done, s1o_valid, s1i_rdy} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ctrl got=%b exp=0000", {busy, done, s1o_valid, s1i_rdy});
        end
        checks++;
        if ({cycle_count, beats_in, beats_out, err_count} !== 112'd0) begin
            failures++;
            $display("FAIL reset_counters got=%h/%h/%h/%h exp=0",
                     cycle_count, beats_in, beats_out, err_count);
        end
        $display("reset done");
    endtask

    task automatic test_echo_basic();
        logic [31:0] q [$];
        int acc;
        q.push_back(32'd5); q.push_back(32'd7); q.push_back(32'd1);
        s1o_rdy = 1'b1;
        start_run(2'b00, 32'd3);
        feed_echo(q, 50, acc);
        wait_done(50);
        checks++;
        if (beats_in !== 32'd3 || beats_out !== 32'd3 || out_cnt != 3) begin
            failures++;
            $display("FAIL echo_beats got in=%0d out=%0d seen=%0d exp=3", beats_in, beats_out, out_cnt);
        end
        checks++;
        if (cycle_count !== 32'd4) begin
            failures++;
            $display("FAIL echo_cycles got=%0d exp=4", cycle_count);
        end
        $display("echo basic run complete");
    endtask

    task automatic test_backpressure();
        logic [31:0] q [$];
        logic [31:0] r [$];
        int acc;
        for (int i = 0; i < 6; i++) q.push_back(32'(i * 3 + 100));
        s1o_rdy = 1'b0;
        start_run(2'b00, 32'd6);
        feed_echo(q, 10, acc);
        checks++;
        if (acc != DEPTH || s1i_rdy !== 1'b0 || beats_out !== 32'd0) begin
            failures++;
            $display("FAIL bp_stall got acc=%0d rdy=%b out=%0d exp acc=%0d rdy=0 out=0",
                     acc, s1i_rdy, beats_out, DEPTH);
        end
        s1o_rdy = 1'b1;
        for (int i = acc; i < 6; i++) r.push_back(q[i]);
        feed_echo(r, 50, acc);
        wait_done(50);
        checks++;
        if (out_cnt != 6 || beats_out !== 32'd6 || beats_in !== 32'd6 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL bp_delivery got seen=%0d out=%0d in=%0d left=%0d exp 6/6/6/0",
                     out_cnt, beats_out, beats_in, exp_q.size());
        end
        $display("backpressure run complete");
    endtask

    task automatic test_generate();
        s1o_rdy = 1'b1;
        start_run(2'b01, 32'd2);
        exp_q.push_back(gen_pat(32'd0));
        exp_q.push_back(gen_pat(32'd1));
        wait_done(50);
        checks++;
        if (cycle_count !== 32'd3) begin
            failures++;
            $display("FAIL gen_cycles got=%0d exp=3", cycle_count);
        end
        checks++;
        if (beats_out !== 32'd2 || beats_in !== 32'd0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL gen_beats got out=%0d in=%0d left=%0d exp 2/0/0",
                     beats_out, beats_in, exp_q.size());
        end
        $display("generate run complete");
    endtask

    task automatic test_check();
        int acc;
        s1o_rdy = 1'b1;
        start_run(2'b10, 32'd2);
        feed_check(2, 1, 50, acc);
        wait_done(50);
        checks++;
        if (err_count !== 16'd1) begin
            failures++;
            $display("FAIL chk_err got=%0d exp=1", err_count);
        end
        checks++;
        if (valid_seen != 0 || beats_in !== 32'd2 || cycle_count !== 32'd2) begin
            failures++;
            $display("FAIL chk_misc got valid=%0d in=%0d cyc=%0d exp 0/2/2",
                     valid_seen, beats_in, cycle_count);
        end
        $display("check run complete err=%0d", err_count);
    endtask

    task automatic test_wrap();
        logic [31:0] q [$];
        int acc;
        q.push_back(32'hFFFFFFFF); q.push_back(32'd2);
        s1o_rdy = 1'b1;
        start_run(2'b00, 32'd2);
        feed_echo(q, 50, acc);
        wait_done(50);
        checks++;
        if (beats_out !== 32'd2 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_beats got out=%0d left=%0d exp 2/0", beats_out, exp_q.size());
        end
        $display("wrap run complete");
    endtask

    task automatic test_saturate();
        int acc;
        s1o_rdy = 1'b1;
        start_run(2'b10, 32'd8200);
        feed_check(8200, 2, 9000, acc);
        wait_done(50);
        checks++;
        if (err_count !== 16'hFFFF || acc != 8200) begin
            failures++;
            $display("FAIL saturate got err=%h acc=%0d exp FFFF/8200", err_count, acc);
        end
        $display("saturation run complete err=%h", err_count);
    endtask

    task automatic test_zero_target();
        start_run(2'b00, 32'd0);
        checks++;
        if (busy !== 1'b0 || cycle_count !== 32'd0 || err_count !== 16'd0) begin
            failures++;
            $display("FAIL zero_start got busy=%b cyc=%0d err=%0d exp 0/0/0",
                     busy, cycle_count, err_count);
        end
        wait_done(5);
        $display("zero-target start complete");
    endtask

    task automatic test_reset_mid();
        logic [31:0] q [$];
        int acc;
        q.push_back(32'd9); q.push_back(32'd10);
        s1o_rdy = 1'b0;
        start_run(2'b00, 32'd2);
        feed_echo(q, 20, acc);
        checks++;
        if (busy !== 1'b1 || s1o_valid !== 1'b1 || acc != 2) begin
            failures++;
            $display("FAIL mid_pre got busy=%b valid=%b acc=%0d exp 1/1/2", busy, s1o_valid, acc);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        checks++;
        if (s1o_valid !== 1'b0 || busy !== 1'b0 || beats_in !== 32'd0 || cycle_count !== 32'd0) begin
            failures++;
            $display("FAIL mid_reset got valid=%b busy=%b in=%0d cyc=%0d exp 0",
                     s1o_valid, busy, beats_in, cycle_count);
        end
        s1o_rdy = 1'b1;
        repeat (4) tick();
        checks++;
        if (done_seen != 0 || out_cnt != 0) begin
            failures++;
            $display("FAIL mid_nodone got done=%0d out=%0d exp 0/0", done_seen, out_cnt);
        end
        $display("reset mid-run complete");
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        done_seen   = 0;
        out_cnt     = 0;
        valid_seen  = 0;
        in_acc      = 1'b0;
        m_sum       = 32'd0;
        m_k         = 32'd0;
        rst_n       = 1'b0;
        s1i_valid   = 1'b0;
        s1i_data    = '0;
        s1o_rdy     = 1'b0;
        mode        = 2'b00;
        start       = 1'b0;
        beat_target = 32'd0;
        test_reset();
        test_echo_basic();
        test_backpressure();
        test_generate();
        test_check();
        test_wrap();
        test_zero_target();
        test_saturate();
        test_reset_mid();
        test_echo_basic();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
